elev_request_queue: RTL and testbench

Per-car request scheduler feeding the car's driver stage. It latches floor call buttons into a pending set and picks the next destination with a directional scan: keep the current travel direction while calls remain ahead, otherwise reverse. It presents `go`/`des` to the driver, clears calls on arrival and times the door dwell. One instance exists per car, directly upstream of the driver controller.

---
 rtl/elev_pkg.sv | 23 ++
 rtl/elev_request_queue_floor_picker.sv | 78 +++++++
 rtl/elev_request_queue.sv | 171 +++++++++++++++++
 tb/tb_elev_request_queue.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared types and constants for the per-car request scheduler (elev_request_queue).
package elev_pkg;

  localparam int FLOORS_DEF = 4;
  localparam logic [FLOORS_DEF-1:0] FLOOR_NONE = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DWELL = 2'd2
  } q_state_t;

  // Works for floor vectors up to 32 bits wide (zero-extended by the caller).
  function automatic logic is_onehot(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += int'(v[i]);
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/elev_request_queue_floor_picker.sv
// Directional scan: nearest pending floor ahead in dir_up, else nearest behind (flip=1).
module floor_picker
  import elev_pkg::*;
#(
  parameter int FLOORS = FLOORS_DEF
) (
  input  logic [FLOORS-1:0] pending,
  input  logic [FLOORS-1:0] cur_floor,
  input  logic              dir_up,
  output logic [FLOORS-1:0] target,
  output logic              found,
  output logic              flip
);

  int                cur_idx;
  logic              up_found;
  logic              dn_found;
  logic [FLOORS-1:0] up_t;
  logic [FLOORS-1:0] dn_t;

  // The later hit in each scan order overwrites earlier ones, leaving the nearest floor.
  always_comb begin
    cur_idx  = 0;
    up_found = 1'b0;
    dn_found = 1'b0;
    up_t     = '0;
    dn_t     = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (cur_floor[i]) begin
        cur_idx = i;
      end else begin
        cur_idx = cur_idx;
      end
    end
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (i > cur_idx && pending[i]) begin
        up_found = 1'b1;
        up_t     = '0;
        up_t[i]  = 1'b1;
      end else begin
        up_found = up_found;
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (i < cur_idx && pending[i]) begin
        dn_found = 1'b1;
        dn_t     = '0;
        dn_t[i]  = 1'b1;
      end else begin
        dn_found = dn_found;
      end
    end
  end

  always_comb begin
    target = '0;
    found  = 1'b0;
    flip   = 1'b0;
    if (dir_up && up_found) begin
      target = up_t;
      found  = 1'b1;
    end else if (!dir_up && dn_found) begin
      target = dn_t;
      found  = 1'b1;
    end else if (dir_up && dn_found) begin
      target = dn_t;
      found  = 1'b1;
      flip   = 1'b1;
    end else if (!dir_up && up_found) begin
      target = up_t;
      found  = 1'b1;
      flip   = 1'b1;
    end else begin
      found = 1'b0;
    end
  end

endmodule

// File: rtl/elev_request_queue.sv
// Per-car call latch and scan scheduler driving go/des; door dwell counter is
// compiled in only when ELEV_DWELL_EN is defined (otherwise DWELL lasts one cycle).
module elev_request_queue
  import elev_pkg::*;
#(
  parameter int FLOORS       = FLOORS_DEF,
  parameter int DWELL_CYCLES = 200_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] req_btn,
  input  logic [FLOORS-1:0] cur_floor,
  output logic              go,
  output logic [FLOORS-1:0] des,
  output logic              dir_up,
  output logic [FLOORS-1:0] pending,
  output logic              door_open,
  output logic              fault
);

  localparam logic [FLOORS-1:0] NONE = '1;

  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("DWELL_CYCLES must be at least 1");
  end

  q_state_t          state_r, state_n;
  logic [FLOORS-1:0] pending_r, pending_n, clr;
  logic [FLOORS-1:0] des_r, des_n, target;
  logic              go_r, go_n, dir_r, dir_n, fault_r, fault_n;
  logic              found, flip, pos_ok;

`ifdef ELEV_DWELL_EN
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_CYCLES - 1);
  logic [CW-1:0] cnt_r, cnt_n;
  logic          door_r, door_n;
`endif

  floor_picker #(.FLOORS(FLOORS)) u_pick (
    .pending   (pending_r),
    .cur_floor (cur_floor),
    .dir_up    (dir_r),
    .target    (target),
    .found     (found),
    .flip      (flip)
  );

  assign pos_ok = is_onehot(32'(cur_floor));

  // Next-state, next-output and call clear mask; a clear always beats a new press.
  always_comb begin
    state_n = state_r;
    clr     = '0;
    go_n    = go_r;
    des_n   = des_r;
    dir_n   = dir_r;
    fault_n = fault_r;
`ifdef ELEV_DWELL_EN
    cnt_n   = cnt_r;
    door_n  = door_r;
`endif
    if (!pos_ok || fault_r) begin
      fault_n = 1'b1;
      go_n    = 1'b0;
      des_n   = NONE;
      state_n = IDLE;
`ifdef ELEV_DWELL_EN
      door_n  = 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (|(pending_r & cur_floor)) begin
            clr     = cur_floor;
            state_n = DWELL;
`ifdef ELEV_DWELL_EN
            door_n  = 1'b1;
            cnt_n   = CNT_LOAD;
`endif
          end else if (found) begin
            des_n   = target;
            go_n    = 1'b1;
            dir_n   = flip ? ~dir_r : dir_r;
            state_n = MOVE;
          end else begin
            state_n = IDLE;
          end
        end
        MOVE: begin
          if ((cur_floor == des_r) || (|(pending_r & cur_floor))) begin
            clr     = cur_floor;
            go_n    = 1'b0;
            des_n   = NONE;
            state_n = DWELL;
`ifdef ELEV_DWELL_EN
            door_n  = 1'b1;
            cnt_n   = CNT_LOAD;
`endif
          end else if (found && !flip && (target != des_r)) begin
            // des is still pending, so a nearer hit ahead lies strictly before it.
            des_n = target;
          end else begin
            state_n = MOVE;
          end
        end
        DWELL: begin
          clr = cur_floor;
`ifdef ELEV_DWELL_EN
          if (cnt_r == '0) begin
            door_n  = 1'b0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt_r - CW'(1);
          end
`else
          state_n = IDLE;
`endif
        end
        default: begin
          go_n    = 1'b0;
          des_n   = NONE;
          state_n = IDLE;
        end
      endcase
    end
    pending_n = (pending_r | req_btn) & ~clr;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      pending_r <= '0;
      go_r      <= 1'b0;
      des_r     <= NONE;
      dir_r     <= 1'b1;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      pending_r <= pending_n;
      go_r      <= go_n;
      des_r     <= des_n;
      dir_r     <= dir_n;
      fault_r   <= fault_n;
    end
  end

`ifdef ELEV_DWELL_EN
  // Door dwell timer and door indicator.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      door_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_n;
      door_r <= door_n;
    end
  end
  assign door_open = door_r;
`else
  assign door_open = 1'b0;
`endif

  assign go      = go_r;
  assign des     = des_r;
  assign dir_up  = dir_r;
  assign pending = pending_r;
  assign fault   = fault_r;

endmodule

// File: tb/tb_elev_request_queue.sv
// Table-driven bench for elev_request_queue with a per-cycle expected-value scoreboard.
module tb_elev_request_queue;

  localparam int DW = 4;
`ifdef ELEV_DWELL_EN
  localparam int   DW_EXP = DW;
  localparam logic DE     = 1'b1;
`else
  localparam int   DW_EXP = 1;
  localparam logic DE     = 1'b0;
`endif
  localparam logic [3:0] NN = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_btn = 4'b0000;
  logic [3:0] cur_floor = 4'b0001;
  logic       go, dir_up, door_open, fault;
  logic [3:0] des, pending;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] cur;
    logic       go;
    logic [3:0] des;
    logic       dir;
    logic [3:0] pend;
    logic       door;
    logic       fault;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   step_no = 0;

  elev_request_queue #(.FLOORS(4), .DWELL_CYCLES(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_btn   (req_btn),
    .cur_floor (cur_floor),
    .go        (go),
    .des       (des),
    .dir_up    (dir_up),
    .pending   (pending),
    .door_open (door_open),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] cf, logic g,
                              logic [3:0] d, logic dr, logic [3:0] p, logic dor, logic f);
    vec_t v;
    v.rst = r; v.req = rq; v.cur = cf; v.go = g; v.des = d;
    v.dir = dr; v.pend = p; v.door = dor; v.fault = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL step %0d %s: got %b expected %b", step_no, name, act, exp);
    end
  endtask

  task automatic cyc(input vec_t v);
    vec_t e;
    rst       = v.rst;
    req_btn   = v.req;
    cur_floor = v.cur;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("go",        {3'b000, go},        {3'b000, e.go});
    chk("des",       des,                 e.des);
    chk("dir_up",    {3'b000, dir_up},    {3'b000, e.dir});
    chk("pending",   pending,             e.pend);
    chk("door_open", {3'b000, door_open}, {3'b000, e.door});
    chk("fault",     {3'b000, fault},     {3'b000, e.fault});
    step_no++;
  endtask

  initial begin
    //                rst  req      cur      go    des      dir   pend     door  fault
    // basic call and arrival
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0001, 1'b0, NN,      1'b1, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b1000, 4'b0001, 1'b0, NN,      1'b1, 4'b1000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0001, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0010, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b1000, 1'b0, NN,      1'b1, 4'b0000, DE,   1'b0));
    // retarget to a nearer call ahead
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0001, 1'b0, NN,      1'b1, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b1000, 4'b0001, 1'b0, NN,      1'b1, 4'b1000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0001, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0100, 4'b0010, 1'b1, 4'b1000, 1'b1, 4'b1100, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0010, 1'b1, 4'b0100, 1'b1, 4'b1100, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0100, 1'b0, NN,      1'b1, 4'b1000, DE,   1'b0));
    // reset mid-MOVE drops pending calls
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0001, 1'b0, NN,      1'b1, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b1010, 4'b0001, 1'b0, NN,      1'b1, 4'b1010, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0001, 1'b1, 4'b0010, 1'b1, 4'b1010, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0001, 1'b0, NN,      1'b1, 4'b0000, 1'b0, 1'b0));
    // invalid position is sticky until reset
    vecs.push_back(mk(1'b0, 4'b0100, 4'b0001, 1'b0, NN,      1'b1, 4'b0100, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0001, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0110, 1'b0, NN,      1'b1, 4'b0100, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0001, 1'b0, NN,      1'b1, 4'b0100, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0100, 1'b0, NN,      1'b1, 4'b0100, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0100, 1'b0, NN,      1'b1, 4'b0000, 1'b0, 1'b0));
    // no call above: reverse and take nearest below
    vecs.push_back(mk(1'b0, 4'b0011, 4'b0100, 1'b0, NN,      1'b1, 4'b0011, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0100, 1'b1, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0010, 1'b0, NN,      1'b0, 4'b0001, DE,   1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i]);
    end

    // dwell at 0010 with that floor's button held: the call is absorbed
    for (int i = 0; i < DW_EXP; i++) begin
      cyc(mk(1'b0, 4'b0010, 4'b0010, 1'b0, NN, 1'b0, 4'b0001,
             (i < DW_EXP - 1) ? DE : 1'b0, 1'b0));
    end
    cyc(mk(1'b0, 4'b0000, 4'b0010, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0));
    cyc(mk(1'b0, 4'b0000, 4'b0001, 1'b0, NN,      1'b0, 4'b0000, DE,   1'b0));
    for (int i = 0; i < DW_EXP; i++) begin
      cyc(mk(1'b0, 4'b0000, 4'b0001, 1'b0, NN, 1'b0, 4'b0000,
             (i < DW_EXP - 1) ? DE : 1'b0, 1'b0));
    end
    cyc(mk(1'b0, 4'b0000, 4'b0001, 1'b0, NN, 1'b0, 4'b0000, 1'b0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
